// File: rtl/cpu_fetch_seq_if.sv
// Instruction-memory read channel and decode-side FIFO head, grouped for the fetch sequencer.
// The fetch sequencer is the master side; memory/decode models attach as slave.
interface cpu_fetch_seq_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               dec_valid;
    logic [INSTR_W-1:0] dec_instr;
    logic [ADDR_W-1:0]  dec_pc;
    logic               dec_ready;

    modport master (
        output imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
        input  imem_ack, imem_rdata, dec_ready
    );

    modport slave (
        input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
        output imem_ack, imem_rdata, dec_ready
    );
endinterface

// File: rtl/cpu_fetch_seq.sv
// Fetch sequencer: one-outstanding imem reads, small instruction FIFO to decode,
// and pc_next generation (advance on fetch, hold, or branch redirect).
module cpu_fetch_seq #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 2,
    parameter int PC_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_cur,
    output logic [ADDR_W-1:0] pc_next,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt,
    cpu_fetch_seq_if.master   bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    entry_t             fifo_mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count, count_nxt;
    state_t             state, state_nxt;
    logic               discard, discard_nxt;
    logic [ADDR_W-1:0]  addr_q, addr_nxt;
    logic               fire, push, pop;

    assign fire = (state == BUSY) & bus.imem_ack;
    assign push = fire & ~discard & ~branch_taken;
    assign pop  = bus.dec_valid & bus.dec_ready;

    // A branch flushes the FIFO outright; a same-cycle pop is irrelevant.
    always_comb begin
        count_nxt = count;
        if (branch_taken) count_nxt = '0;
        else              count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    end

    always_comb begin
        state_nxt   = state;
        discard_nxt = discard;
        addr_nxt    = addr_q;
        pc_next     = pc_cur;
        if (rst) begin
            pc_next = '0;
        end else if (branch_taken) begin
            pc_next = branch_target;
            if (state == BUSY) begin
                // An unacked read still owes us a response; mark it to be dropped.
                if (bus.imem_ack) begin
                    state_nxt   = IDLE;
                    discard_nxt = 1'b0;
                end else begin
                    discard_nxt = 1'b1;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (!halt && count < DEPTH_C) begin
                        state_nxt = BUSY;
                        addr_nxt  = pc_cur;
                    end
                end
                BUSY: begin
                    if (bus.imem_ack) begin
                        if (discard) begin
                            discard_nxt = 1'b0;
                            state_nxt   = IDLE;
                        end else begin
                            pc_next = addr_q + STEP;
                            if (!halt && count_nxt < DEPTH_C) addr_nxt  = addr_q + STEP;
                            else                              state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            discard <= 1'b0;
            addr_q  <= '0;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else begin
            state   <= state_nxt;
            discard <= discard_nxt;
            addr_q  <= addr_nxt;
            count   <= count_nxt;
            if (branch_taken) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {addr_q, bus.imem_rdata};
    end

    assign bus.imem_req  = (state == BUSY);
    assign bus.imem_addr = addr_q;
    assign bus.dec_valid = (count != '0);
    assign bus.dec_instr = fifo_mem[rd_ptr].instr;
    assign bus.dec_pc    = fifo_mem[rd_ptr].pc;
endmodule

// File: tb/tb_cpu_fetch_seq.sv
// Bench for cpu_fetch_seq: acts as PC register and instruction memory, and checks
// the decode stream against a sequential-fetch-with-redirect reference.
module tb_cpu_fetch_seq;
    localparam int AW = 16, IW = 32, DEPTH = 2, STEP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc_cur, pc_next, branch_target;
    logic          branch_taken, halt;

    cpu_fetch_seq_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

    cpu_fetch_seq #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .PC_STEP(STEP)) dut (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_next(pc_next),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .halt(halt), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mem_word(logic [AW-1:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    int n_pass = 0, n_chk = 0;
    // Reference: FIFO contents as PCs, next architectural fetch address, stale-response flag
    logic [AW-1:0] mq[$];
    logic [AW-1:0] fired[$], pn_log[$], pops[$];
    logic [AW-1:0] exp_fetch = '0;
    bit            stale = 0;
    bit            p_rst = 1, p_req = 0, p_fire = 0, p_halt = 0, p_br = 0;
    logic [AW-1:0] p_addr = '0;
    int            n0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        logic [AW-1:0] pn_exp, pn_dut;
        bit fire, pop, req;
        #1;
        req = bus.imem_req;
        if (p_rst) begin
            chk("post_rst_req", 32'(req), 0);
        end else begin
            if (p_req && !p_fire) begin
                chk("hold_req", 32'(req), 1);
                chk("hold_addr", 32'(bus.imem_addr), 32'(p_addr));
            end
            if ((p_halt || p_br) && (!p_req || p_fire)) chk("no_launch", 32'(req), 0);
        end
        chk("dec_valid", 32'(bus.dec_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("dec_pc", 32'(bus.dec_pc), 32'(mq[0]));
            chk("dec_instr", bus.dec_instr, mem_word(mq[0]));
        end
        fire   = req && bus.imem_ack;
        pn_exp = rst ? '0 : branch_taken ? branch_target :
                 (fire && !stale) ? bus.imem_addr + AW'(STEP) : pc_cur;
        pn_dut = pc_next;
        chk("pc_next", 32'(pn_dut), 32'(pn_exp));
        if (rst) begin
            mq.delete();
            stale     = 0;
            exp_fetch = '0;
        end else begin
            if (fire && !stale) chk("fetch_addr", 32'(bus.imem_addr), 32'(exp_fetch));
            pop = (mq.size() != 0) && bus.dec_ready;
            if (branch_taken) begin
                mq.delete();
                stale     = req && !bus.imem_ack;
                exp_fetch = branch_target;
            end else begin
                if (pop) pops.push_back(mq.pop_front());
                if (fire && !stale) begin
                    mq.push_back(bus.imem_addr);
                    fired.push_back(bus.imem_addr);
                    pn_log.push_back(pn_dut);
                    exp_fetch = bus.imem_addr + AW'(STEP);
                end
                if (fire) stale = 0;
                chk("fifo_cap", 32'(mq.size() <= DEPTH), 1);
            end
        end
        p_rst  = rst;
        p_req  = req;
        p_fire = fire;
        p_halt = halt;
        p_br   = branch_taken;
        p_addr = bus.imem_addr;
        @(posedge clk);
        #1 pc_cur = pn_dut;
        @(negedge clk);
    endtask

    task automatic set_pc(logic [AW-1:0] v);
        pc_cur    = v;
        exp_fetch = v;
    endtask

    initial begin
        rst = 1; halt = 0; branch_taken = 0; branch_target = '0; pc_cur = '0;
        bus.imem_ack = 0; bus.dec_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step();
        chk("reset_req", 32'(bus.imem_req), 0);
        chk("reset_dv", 32'(bus.dec_valid), 0);

        // Zero-wait streaming from 0
        rst = 0; set_pc('0); bus.dec_ready = 1; bus.imem_ack = 1;
        fired.delete(); pn_log.delete(); pops.delete();
        repeat (6) step();
        chk("seq_addr0", 32'(fired[0]), 32'h0000);
        chk("seq_addr1", 32'(fired[1]), 32'h0004);
        chk("seq_addr2", 32'(fired[2]), 32'h0008);
        chk("seq_pn0", 32'(pn_log[0]), 32'h0004);
        chk("seq_pn1", 32'(pn_log[1]), 32'h0008);
        chk("seq_pn2", 32'(pn_log[2]), 32'h000C);
        chk("seq_pop0", 32'(pops[0]), 32'h0000);
        chk("seq_pop1", 32'(pops[1]), 32'h0004);

        // Drain, then stall decode: exactly DEPTH fetches land
        halt = 1;
        repeat (4) step();
        halt = 0; bus.dec_ready = 0;
        n0 = fired.size();
        repeat (6) step();
        chk("stall_fetches", 32'(fired.size() - n0), 32'(DEPTH));
        chk("stall_req", 32'(bus.imem_req), 0);
        chk("stall_dv", 32'(bus.dec_valid), 1);
        bus.dec_ready = 1;
        n0 = fired.size();
        repeat (8) step();
        chk("resume_progress", 32'(fired.size() > n0), 1);

        // Ack delayed by three cycles
        bus.imem_ack = 0;
        repeat (3) begin
            step();
            chk("wait_req", 32'(bus.imem_req), 1);
        end
        bus.imem_ack = 1;
        step();

        // Branch while the read of 0x0008 is outstanding
        rst = 1; step(); rst = 0; set_pc('0);
        for (int i = 0; i < 12; i++) begin
            if (bus.imem_req && bus.imem_addr == 16'h0008) break;
            bus.imem_ack = 1;
            step();
        end
        chk("reach_0008", 32'(bus.imem_addr), 32'h0008);
        bus.imem_ack = 0;
        step();
        branch_taken = 1; branch_target = 16'h0100;
        step();
        branch_taken = 0; bus.imem_ack = 1;
        step();
        chk("stale_dropped_dv", 32'(bus.dec_valid), 0);
        pops.delete();
        repeat (6) step();
        chk("first_after_branch", 32'(pops[0]), 32'h0100);

        // Branch coinciding with ack and pop
        chk("b2b_state", 32'(bus.dec_valid && bus.imem_req), 1);
        branch_taken = 1; branch_target = 16'h0200;
        step();
        branch_taken = 0;
        chk("flush_dv", 32'(bus.dec_valid), 0);
        chk("flush_req", 32'(bus.imem_req), 0);
        repeat (4) step();

        // Address wrap at top of space
        rst = 1; step(); rst = 0; set_pc(16'hFFFC);
        fired.delete(); pn_log.delete();
        repeat (3) step();
        chk("wrap_addr", 32'(fired[0]), 32'hFFFC);
        chk("wrap_pn", 32'(pn_log[0]), 32'h0000);
        chk("wrap_next", 32'(fired[1]), 32'h0000);

        // Halt with a read in flight
        bus.imem_ack = 0;
        step();
        halt = 1;
        step();
        n0 = fired.size();
        bus.imem_ack = 1;
        step();
        chk("halt_completes", 32'(fired.size() - n0), 1);
        repeat (3) begin
            step();
            chk("halt_req", 32'(bus.imem_req), 0);
        end
        halt = 0; bus.imem_ack = 0;

        // Reset during an outstanding read, then a stray ack
        repeat (2) step();
        chk("pre_rst_req", 32'(bus.imem_req), 1);
        rst = 1; step();
        rst = 0; halt = 1; bus.imem_ack = 1;
        chk("rst_mid_req", 32'(bus.imem_req), 0);
        chk("rst_mid_dv", 32'(bus.dec_valid), 0);
        repeat (3) begin
            step();
            chk("stray_ack_dv", 32'(bus.dec_valid), 0);
        end
        halt = 0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(199) == 0);
            bus.imem_ack  = $urandom_range(1);
            bus.dec_ready = ($urandom_range(9) < 7);
            halt          = ($urandom_range(9) == 0);
            branch_taken  = ($urandom_range(29) == 0);
            branch_target = AW'($urandom) & 16'hFFFC;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cpu_fetch_seq.md
Name: cpu_fetch_seq

Overview:
- Fetch sequencer at the consumer end of the program counter.
- Reads the current PC value, issues instruction-memory reads with a req/ack handshake, and buffers fetched words in a small FIFO for decode.
- Generates pc_next for the PC register: sequential advance, hold, or branch redirect.
- Sits between the PC register, instruction memory and the decode stage.

Parameters:
- ADDR_W, 16: PC / instruction address width.
- INSTR_W, 32: instruction word width.
- DEPTH, 2: instruction FIFO entries (power of 2, ≥2).
- PC_STEP, 4: PC increment per fetched instruction (byte addressing).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- pc_cur  in  ADDR_W  current PC from the PC register.
- pc_next  out  ADDR_W  next PC to the PC register (combinational).
- imem_req  out  1  read request.
- imem_addr  out  ADDR_W  read address, registered.
- imem_ack  in  1  read data valid; completes the outstanding request.
- imem_rdata  in  INSTR_W  read data, valid with imem_ack.
- branch_taken  in  1  redirect strobe, one cycle.
- branch_target  in  ADDR_W  redirect address.
- halt  in  1  inhibits new requests.
- dec_valid  out  1  FIFO head valid.
- dec_instr  out  INSTR_W  FIFO head instruction.
- dec_pc  out  ADDR_W  address of FIFO head instruction.
- dec_ready  in  1  decode accepts the head.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, FIFO count=0, discard=0, imem_addr=0.
  - Outputs go low from the next cycle: imem_req=0, dec_valid=0.
  - pc_next=0 while rst is high.
  - An imem_ack arriving in IDLE is ignored.
- Handshake:
  - At most one request outstanding.
  - imem_req = (state==BUSY).
  - imem_addr is stable while imem_req=1.
  - A request completes in the first cycle with imem_req & imem_ack; ack may arrive in the same cycle req first rises.
- Slot reservation: launch allowed only when count < DEPTH, so a push never overflows.
- IDLE → BUSY when !halt & !branch_taken & count<DEPTH; imem_addr <= pc_cur.
- BUSY with ack and discard=0 and !branch_taken:
  - Push {imem_addr, imem_rdata}.
  - pc_next = imem_addr+PC_STEP (modulo 2^ADDR_W, wraps FFFC→0000 for step 4).
  - Back-to-back: stay BUSY with imem_addr <= imem_addr+PC_STEP if !halt and post-update count (push and any same-cycle pop) < DEPTH; else → IDLE.
- BUSY with ack and discard=1: drop data, discard<=0, → IDLE; pc_next=pc_cur.
- BUSY without ack: hold req/addr; pc_next=pc_cur.
- branch_taken (highest priority):
  - pc_next=branch_target.
  - FIFO flushed (count<=0, any same-cycle pop ignored).
  - No launch that cycle.
  - If BUSY without ack: discard<=1, stay BUSY.
  - If BUSY with ack: data dropped, → IDLE.
  - If IDLE: stay IDLE.
  - Next cycle pc_cur=target and launch proceeds normally.
- Otherwise pc_next=pc_cur (hold).
- FIFO:
  - dec_valid = count!=0; dec_instr/dec_pc show the head.
  - Pop on dec_valid & dec_ready.
  - Push and pop may occur in the same cycle; count unchanged.
  - Order preserved.
- halt blocks launches only; the outstanding request completes and is buffered; FIFO drain continues.
- Latency: pc_cur change → imem_req one cycle later. Ack → dec_valid next cycle.

Test Plan:
- Reset, then pc_cur=0x0000, dec_ready=1, zero-wait ack:
  - Requests at 0x0000, 0x0004, 0x0008 back-to-back.
  - pc_next sequence 0x0004, 0x0008, 0x000C.
  - dec_pc matches each request with its rdata.
- dec_ready=0 with DEPTH=2:
  - Exactly two fetches complete, then imem_req=0 and count=2.
  - Raising dec_ready resumes at the next address with no loss or duplicate.
- Ack delayed 3 cycles: imem_req and imem_addr stable throughout; pc_next=pc_cur until the ack cycle.
- branch_taken (target 0x0100) while a request to 0x0008 is outstanding:
  - FIFO flushed; the later 0x0008 ack is dropped.
  - Next request at 0x0100; first dec_pc after flush is 0x0100.
- branch_taken in the same cycle as ack and dec_ready pop: data dropped, count=0, pc_next=branch_target.
- Boundary and control cases:
  - pc_cur=0xFFFC gives pc_next=0x0000.
  - halt mid-stream: outstanding completes, no new imem_req.
  - rst asserted mid-request: next cycle imem_req=0, dec_valid=0; a later stray ack is ignored.
